datapath_bird: RTL
==================

// Module: datapath_bird
// PURPOSE
//  Bird datapath paired with the bird controller FSM. Decodes the controller's 3-bit state,
//  generates the frame tick, and updates the bird's vertical position and fall velocity.
//  Detects ceiling, floor and pipe collisions and returns the sticky 'touched' flag to the FSM.
//  Sits between the control FSM and the VGA draw logic, which reads bird_y.
// PARAMETERS
//  Y_W        7       width of the y coordinate
//  SCREEN_H   120     playfield height in pixels
//  BIRD_X     40      fixed bird column (left edge)
//  BIRD_W     4       bird width
//  BIRD_H     4       bird height
//  START_Y    56      y loaded in START
//  RISE_STEP  2       pixels moved up per frame while RAISING
//  GRAVITY    1       velocity increment per frame while FALLING
//  VMAX       4       maximum fall velocity (pixels/frame)
//  PIPE_W     8       pipe width
//  GAP_H      30      pipe gap height
//  FRAME_DIV  833333  clk cycles per frame tick (60 Hz at 50 MHz)
// PORTS
//  clk        in   1    system clock
//  resetn     in   1    asynchronous active-low reset
//  state      in   3    controller state: READY=000 START=010 RAISING=110 FALLING=011 STOP=001
//  pipe_x     in   8    left edge of the current pipe (unsigned)
//  gap_y      in   Y_W  top edge of the current pipe gap
//  bird_y     out  Y_W  bird top edge
//  touched    out  1    sticky collision flag to the controller
//  frame      out  1    one-cycle frame tick
//  score      out  8    pipes passed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: clk and resetn are the only clock and reset. resetn low asynchronously forces
//   bird_y=START_Y, vel=0, touched=0, frame=0, score=0 and frame counter=0.
//   Reset mid-game discards all state; no partial update completes.
//  Frame counter: free-runs 0..FRAME_DIV-1. frame=1 for exactly one cycle when it wraps.
//  State decode: unknown codes (100, 101, 111) act as READY.
//  READY: bird_y, vel and touched hold. No motion.
//  START: bird_y<=START_Y, vel<=0, touched<=0 and score<=0 on every cycle, independent of frame.
//  RAISING, on frame:
//   - bird_y<=max(bird_y-RISE_STEP, 0) and vel<=0.
//   - Subtraction is done at Y_W+1 bits so it cannot wrap.
//  FALLING, on frame:
//   - vel<=min(vel+GRAVITY, VMAX), then bird_y<=min(bird_y+vel_new, SCREEN_H-BIRD_H).
//   - Arithmetic is done at Y_W+1 bits.
//  STOP: all registers hold. touched stays 1.
//  Collision, evaluated only on a frame in RAISING or FALLING, using the new y (ny):
//   - Ceiling: ny==0.
//   - Floor: ny==SCREEN_H-BIRD_H.
//   - Pipe: horizontal overlap (pipe_x<=BIRD_X+BIRD_W-1 && pipe_x+PIPE_W-1>=BIRD_X),
//     AND (ny<gap_y || ny+BIRD_H>gap_y+GAP_H).
//   - Pipe comparisons are 9-bit, no wrap.
//   - Any hit sets touched the cycle after the frame pulse, i.e. in the same edge that commits ny.
//  touched is sticky: cleared only by START or reset.
//   A frame that arrives while touched=1 still moves the bird until the FSM leaves RAISING/FALLING.
//  Simultaneous events:
//   - START overrides frame.
//   - A frame coincident with a state change uses the state sampled on that edge.
// CONFIGURATION
//  BIRD_SCORE_EN defined:
//   - On a frame in RAISING/FALLING with touched=0 and pipe_x+PIPE_W==BIRD_X, score increments.
//   - score saturates at 255 and is cleared in START.
//  BIRD_SCORE_EN undefined: score is tied to 8'd0 and no score logic is built.
// TESTING
//  Reset low mid-FALLING for 1 cycle -> bird_y=56, touched=0 and frame=0 immediately, before any clk edge.
//  FRAME_DIV=4, state=FALLING from y=56, vel=0, over 5 frames -> y = 57, 59, 62, 66, 70 (vel capped at 4).
//  State=RAISING from y=1 -> after 1 frame y=0 and touched=1 on that same edge.
//   Then state=STOP -> y holds 0 and touched holds 1 across 10 frames.
//  pipe_x=38, gap_y=20, y=56, state=FALLING -> ny=57, 57+4>50, so touched=1 one cycle after frame.
//   Then state=START -> touched=0, y=56.
//  BIRD_SCORE_EN, pipe_x=32, clear gap, one frame in FALLING -> score=1.
//   Repeat with touched=1 -> score unchanged.
//   With the macro undefined -> score stays 0.

Source files
------------

// File: rtl/datapath_bird.sv
// Bird datapath: frame tick, vertical motion, collision flag and optional score.
// Optional pipe scoring is built only when BIRD_SCORE_EN is defined.
module datapath_bird #(
    parameter int Y_W       = 7,
    parameter int SCREEN_H  = 120,
    parameter int BIRD_X    = 40,
    parameter int BIRD_W    = 4,
    parameter int BIRD_H    = 4,
    parameter int START_Y   = 56,
    parameter int RISE_STEP = 2,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 4,
    parameter int PIPE_W    = 8,
    parameter int GAP_H     = 30,
    parameter int FRAME_DIV = 833333
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [2:0]     state,
    input  logic [7:0]     pipe_x,
    input  logic [Y_W-1:0] gap_y,
    output logic [Y_W-1:0] bird_y,
    output logic           touched,
    output logic           frame,
    output logic [7:0]     score
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [2:0] ST_START   = 3'b010;
    localparam logic [2:0] ST_RAISING = 3'b110;
    localparam logic [2:0] ST_FALLING = 3'b011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [Y_W:0]     FLOOR_X  = (Y_W+1)'(SCREEN_H - BIRD_H);
    localparam logic [Y_W:0]     RISE_X   = (Y_W+1)'(RISE_STEP);
    localparam logic [Y_W:0]     GRAV_X   = (Y_W+1)'(GRAVITY);
    localparam logic [Y_W:0]     VMAX_X   = (Y_W+1)'(VMAX);
    localparam logic [Y_W-1:0]   START_YV = Y_W'(START_Y);
    localparam logic [8:0]       BIRD_L9  = 9'(BIRD_X);
    localparam logic [8:0]       BIRD_R9  = 9'(BIRD_X + BIRD_W - 1);
    localparam logic [8:0]       PIPE_R9  = 9'(PIPE_W - 1);
    localparam logic [8:0]       PIPE_W9  = 9'(PIPE_W);
    localparam logic [8:0]       BIRD_H9  = 9'(BIRD_H);
    localparam logic [8:0]       GAP_H9   = 9'(GAP_H);

    logic [CNT_W-1:0] frame_cnt_r;
    logic [Y_W-1:0]   vel_r;

    logic             move_s;
    logic             raise_s;
    logic [Y_W:0]     vel_sum_s;
    logic [Y_W-1:0]   vel_new_s;
    logic [Y_W:0]     down_s;
    logic [Y_W:0]     ny_s;
    logic [8:0]       ny9_s;
    logic [8:0]       px9_s;
    logic [8:0]       gap9_s;
    logic             overlap_s;
    logic             hit_s;

    // Next y, next velocity and collision for the current state and inputs
    always_comb begin
        move_s    = 1'b0;
        raise_s   = 1'b0;
        case (state)
            ST_RAISING: begin
                move_s  = 1'b1;
                raise_s = 1'b1;
            end
            ST_FALLING: begin
                move_s  = 1'b1;
                raise_s = 1'b0;
            end
            default: begin
                move_s  = 1'b0;
                raise_s = 1'b0;
            end
        endcase

        vel_sum_s = {1'b0, vel_r} + GRAV_X;
        if (vel_sum_s > VMAX_X) begin
            vel_new_s = VMAX_X[Y_W-1:0];
        end else begin
            vel_new_s = vel_sum_s[Y_W-1:0];
        end

        down_s = {1'b0, bird_y} + {1'b0, vel_new_s};
        if (raise_s) begin
            if ({1'b0, bird_y} >= RISE_X) begin
                ny_s = {1'b0, bird_y} - RISE_X;
            end else begin
                ny_s = '0;
            end
        end else if (down_s > FLOOR_X) begin
            ny_s = FLOOR_X;
        end else begin
            ny_s = down_s;
        end

        // 9-bit compares so pipe_x + PIPE_W and gap_y + GAP_H never wrap
        ny9_s     = 9'(ny_s);
        px9_s     = {1'b0, pipe_x};
        gap9_s    = 9'(gap_y);
        overlap_s = (px9_s <= BIRD_R9) && ((px9_s + PIPE_R9) >= BIRD_L9);
        hit_s     = (ny_s == '0) || (ny_s == FLOOR_X) ||
                    (overlap_s && ((ny9_s < gap9_s) || ((ny9_s + BIRD_H9) > (gap9_s + GAP_H9))));
    end

    // Free-running frame divider with a registered one-cycle tick on wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_r <= '0;
            frame       <= 1'b0;
        end else if (frame_cnt_r == CNT_LAST) begin
            frame_cnt_r <= '0;
            frame       <= 1'b1;
        end else begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
            frame       <= 1'b0;
        end
    end

    // Position, velocity and sticky collision flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bird_y  <= START_YV;
            vel_r   <= '0;
            touched <= 1'b0;
        end else if (state == ST_START) begin
            bird_y  <= START_YV;
            vel_r   <= '0;
            touched <= 1'b0;
        end else if (move_s && frame) begin
            bird_y  <= ny_s[Y_W-1:0];
            vel_r   <= raise_s ? '0 : vel_new_s;
            touched <= touched | hit_s;
        end else begin
            bird_y  <= bird_y;
            vel_r   <= vel_r;
            touched <= touched;
        end
    end

`ifdef BIRD_SCORE_EN
    // Count a pipe as passed when its right edge meets the bird's left edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score <= 8'd0;
        end else if (state == ST_START) begin
            score <= 8'd0;
        end else if (move_s && frame && !touched && ((px9_s + PIPE_W9) == BIRD_L9) &&
                     (score != 8'hFF)) begin
            score <= score + 8'd1;
        end else begin
            score <= score;
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule
